avalon_sdr_writer: RTL
======================

Name: avalon_sdr_writer

Overview:
Write-side companion to the SDRAM Avalon-MM read master. It accepts a stream of 32-bit words over a valid/ready handshake and packs eight words into each 256-bit beat. Each full or final partial beat is issued as a single-beat Avalon-MM write to consecutive SDRAM addresses. It fills the SDRAM region that the read master later fetches from, for example frame data at 32'h2000_0000.

Parameters:
CNT_W, 24, width of the word-count input and of the internal remaining-words counter
WORDS_PER_BEAT, 8, 32-bit words per 256-bit beat; fixed at 8, other values unsupported
BEAT_BYTES, 32, address increment per beat, in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches base_addr and word_count; ignored unless in IDLE
base_addr  in  32  byte address of first beat; must be 32-byte aligned; low 5 bits forced to 0
word_count  in  CNT_W  number of 32-bit words to write
in_data  in  32  stream word
in_valid  in  1  stream word valid
in_ready  out  1  block can accept in_data this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last write is accepted, or the transfer is empty
avm_m0_write  out  1  Avalon write request
avm_m0_writedata  out  256  packed beat
avm_m0_address  out  32  byte address of beat
avm_m0_byteenable  out  32  byte lanes valid
avm_m0_burstcount  out  11  always 11'd1 while writing, 0 otherwise
avm_m0_waitrequest  in  1  slave stall

Behaviour:
- Reset values: all outputs 0; state IDLE; beat register, lane index, address and remaining counter cleared. Reset mid-transfer abandons the transfer at the next edge. No done pulse is issued; a pending write is dropped.
- FSM states:
  - IDLE: in_ready=0, busy=0. On start: addr<=base_addr&~31, remaining<=word_count, lane<=0, beat<=0, be<=0. If word_count==0, go to DONE; otherwise go to FILL.
  - FILL: in_ready=1. On in_valid&&in_ready, store in_data at bits [32*lane+31 : 32*lane], set be bits [4*lane+3 : 4*lane] to 4'hF, lane++ and remaining--. Go to WRITE in the cycle after accepting a word with lane==7 or remaining==1. in_valid gaps simply hold the state.
  - WRITE: in_ready=0. Drive avm_m0_write=1, writedata=beat, address=addr, byteenable=be and burstcount=1. All of these stay stable while waitrequest=1. When waitrequest=0 (write accepted):
    - addr<=addr+32, lane<=0, beat<=0, be<=0.
    - If remaining==0, go to DONE; otherwise go to FILL.
  - DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Partial final beat: unfilled lanes carry data 0 and byteenable 0. Example: 10 words give beat 2 with be=32'h0000_00FF.
- Throughput: at best one word per cycle in FILL, plus a write of at least 1 cycle per beat. There is no overlap of fill and write.
- Address arithmetic is 32-bit modulo and wraps silently at 2^32. The remaining counter never underflows because the FSM leaves FILL at remaining==1.
- start asserted while busy=1 has no effect. Outputs in IDLE are all 0, except that avm_m0_burstcount=0.
- avm_m0_write is asserted only in WRITE; no read is ever issued.

Decomposition:
- Shared package sdr_pkg holds:
  - the Avalon constants AVM_DATA_W=256, AVM_BE_W=32, AVM_BURST_W=11;
  - SDR_FRAME_BASE=32'h2000_0000;
  - the writer state enum typedef (IDLE, FILL, WRITE, DONE).
- One natural sub-module, sdr_beat_packer: lane index, beat register, byteenable build and the full flag. The FSM, counters and Avalon drive stay in the top.

Test Plan:
- start, base_addr=32'h2000_0000, word_count=8, words 1..8 back-to-back, waitrequest=0 -> one write at 32'h2000_0000 with be=32'hFFFF_FFFF and writedata[31:0]=1, [255:224]=8; done pulses once; busy then returns to 0.
- word_count=10, words 1..10 -> writes at 32'h2000_0000 (be all ones) and 32'h2000_0020 (be=32'h0000_00FF, writedata[63:32]=10, upper lanes 0).
- waitrequest held high for 5 cycles on the first write -> write, address, data and byteenable stable all 5 cycles; in_ready=0; write accepted on cycle 6.
- word_count=0 with start -> no avm_m0_write ever asserted; done pulses within 2 cycles of start.
- in_valid toggling every other cycle, word_count=16 -> two full beats at +0 and +32; no word dropped or duplicated (scoreboard).
- reset asserted during WRITE with waitrequest=1 -> next cycle all outputs 0 and state IDLE; a following start with word_count=8 completes normally at the new base_addr.

Source files
------------

// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared Avalon constants and writer state type for the SDRAM masters
package sdr_pkg;
    localparam int AVM_DATA_W  = 256;
    localparam int AVM_BE_W    = 32;
    localparam int AVM_BURST_W = 11;

    localparam logic [31:0] SDR_FRAME_BASE = 32'h2000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } wr_state_t;
endpackage

// File: rtl/sdr_beat_packer.sv
// rtl/sdr_beat_packer.sv - gathers 32-bit words into one 256-bit beat with byte enables
module sdr_beat_packer
    import sdr_pkg::*;
#(
    parameter int WORDS_PER_BEAT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [31:0]           word,
    output logic [AVM_DATA_W-1:0] beat,
    output logic [AVM_BE_W-1:0]   be,
    output logic [2:0]            lane,
    output logic                  full
);
    // clear wins over load: a beat is never started in the cycle it is retired
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            beat <= '0;
            be   <= '0;
            lane <= '0;
        end else if (load) begin
            beat[32*lane +: 32] <= word;
            be[4*lane +: 4]     <= 4'hF;
            lane                <= lane + 3'd1;
        end
    end

    assign full = (lane == 3'(WORDS_PER_BEAT - 1));
endmodule

// File: rtl/avalon_sdr_writer.sv
// rtl/avalon_sdr_writer.sv - packs a 32-bit word stream into single-beat 256-bit Avalon-MM writes
module avalon_sdr_writer
    import sdr_pkg::*;
#(
    parameter int CNT_W          = 24,
    parameter int WORDS_PER_BEAT = 8,
    parameter int BEAT_BYTES     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [CNT_W-1:0]       word_count,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   avm_m0_write,
    output logic [AVM_DATA_W-1:0]  avm_m0_writedata,
    output logic [31:0]            avm_m0_address,
    output logic [AVM_BE_W-1:0]    avm_m0_byteenable,
    output logic [AVM_BURST_W-1:0] avm_m0_burstcount,
    input  logic                   avm_m0_waitrequest
);
    wr_state_t             state;
    logic [31:0]           addr;
    logic [CNT_W-1:0]      remaining;
    logic [AVM_DATA_W-1:0] beat;
    logic [AVM_BE_W-1:0]   be;
    logic [2:0]            lane;
    logic                  full;
    logic                  accept;
    logic                  write_ack;
    logic                  begin_xfer;
    logic                  clear_beat;

    assign accept     = (state == FILL) && in_valid && in_ready;
    assign write_ack  = (state == WRITE) && !avm_m0_waitrequest;
    assign begin_xfer = (state == IDLE) && start;
    assign clear_beat = begin_xfer || write_ack;

    sdr_beat_packer #(
        .WORDS_PER_BEAT(WORDS_PER_BEAT)
    ) u_packer (
        .clk  (clk),
        .reset(reset),
        .clear(clear_beat),
        .load (accept),
        .word (in_data),
        .beat (beat),
        .be   (be),
        .lane (lane),
        .full (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            avm_m0_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr & ~32'h1F;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        // leaving at remaining==1 keeps the counter from underflowing
                        if (full || remaining == CNT_W'(1)) begin
                            state        <= WRITE;
                            in_ready     <= 1'b0;
                            avm_m0_write <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!avm_m0_waitrequest) begin
                        addr         <= addr + 32'(BEAT_BYTES);
                        avm_m0_write <= 1'b0;
                        if (remaining == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus fields are only presented while a write is requested, so the bus idles at zero.
    assign avm_m0_writedata  = avm_m0_write ? beat : '0;
    assign avm_m0_address    = avm_m0_write ? addr : '0;
    assign avm_m0_byteenable = avm_m0_write ? be : '0;
    assign avm_m0_burstcount = avm_m0_write ? AVM_BURST_W'(1) : '0;
endmodule
